// File: rtl/inst_prefetch.sv
// Instruction prefetch stage: issues sequential fetches with one outstanding request and
// pushes {pc, inst} into the instruction queue; redirects discard in-flight fetches.
module inst_prefetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             redirect,
   input  logic [ADDR_WIDTH-1:0]            redirect_pc,
   output logic                             mem_req,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic                             mem_gnt,
   input  logic                             mem_rvalid,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   input  logic                             que_full,
   output logic                             que_write,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] que_wdata,
   output logic                             que_flush
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DROP
   } state_t;

   state_t                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]           ifl_pc_q, ifl_pc_d;
   logic                            mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0]           mem_addr_q, mem_addr_d;
   logic                            que_write_q, que_write_d;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] que_wdata_q, que_wdata_d;
   logic                            que_flush_q, que_flush_d;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ifl_pc_d    = ifl_pc_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      que_write_d = 1'b0;
      que_wdata_d = que_wdata_q;
      que_flush_d = 1'b0;

      if (redirect) begin
         // A grant coinciding with the redirect still leaves a response in flight.
         pc_d        = redirect_pc;
         que_flush_d = 1'b1;
         mem_req_d   = 1'b0;
         unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_REQ:  state_d = mem_gnt ? ST_DROP : ST_IDLE;
            ST_WAIT: state_d = mem_rvalid ? ST_IDLE : ST_DROP;
            ST_DROP: state_d = mem_rvalid ? ST_IDLE : ST_DROP;
            default: state_d = ST_IDLE;
         endcase
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!que_full) begin
                  state_d    = ST_REQ;
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_q;
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  state_d   = ST_WAIT;
                  mem_req_d = 1'b0;
                  ifl_pc_d  = pc_q;
                  pc_d      = pc_q + ADDR_WIDTH'(4);
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state_d     = ST_IDLE;
                  que_write_d = 1'b1;
                  que_wdata_d = {ifl_pc_q, mem_rdata};
               end
            end
            ST_DROP: begin
               if (mem_rvalid) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         ifl_pc_q    <= RESET_PC;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= RESET_PC;
         que_write_q <= 1'b0;
         que_wdata_q <= '0;
         que_flush_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ifl_pc_q    <= ifl_pc_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         que_write_q <= que_write_d;
         que_wdata_q <= que_wdata_d;
         que_flush_q <= que_flush_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign que_write = que_write_q;
   assign que_wdata = que_wdata_q;
   assign que_flush = que_flush_q;

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: vector table, hand-written redirect/reset
// sequences and a randomized run against a pc-arithmetic reference model.
module tb_inst_prefetch;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        que_full;
   logic        que_write;
   logic [63:0] que_wdata;
   logic        que_flush;

   int nChecks = 0;
   int nPass = 0;
   int pushCount = 0;
   int flushCount = 0;
   int expPushes = 0;
   int expFlushes = 0;

   inst_prefetch #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .RESET_PC  (32'h0000_0100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .que_full   (que_full),
      .que_write  (que_write),
      .que_wdata  (que_wdata),
      .que_flush  (que_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Push/flush pulses are tallied independently and must never overlap.
   always @(negedge clk) begin
      if (rst) begin
         if (que_write) pushCount++;
         if (que_flush) flushCount++;
         checkOutput("writeFlushExclusive", 96'(que_write & que_flush), 96'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReq(input logic [31:0] expAddr, output bit ok);
      int guard = 0;
      while (!mem_req && guard < 20) begin
         step();
         guard++;
      end
      checkOutput("reqIssued", 96'(mem_req), 96'd1);
      ok = mem_req;
      if (ok) checkOutput("reqAddr", 96'(mem_addr), 96'(expAddr));
   endtask

   task automatic grantAfter(input int gd, input logic [31:0] expAddr);
      for (int i = 0; i < gd; i++) begin
         step();
         checkOutput("reqHoldStable", {63'd0, mem_req, mem_addr}, {63'd0, 1'b1, expAddr});
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
   endtask

   task automatic applyStimulus(input int gd, input int rd, input logic [31:0] data,
                                input logic [31:0] expAddr);
      bit ok;
      waitReq(expAddr, ok);
      if (!ok) return;
      grantAfter(gd, expAddr);
      for (int k = 1; k <= rd; k++) begin
         checkOutput("waitNoReqNoPush", {94'd0, mem_req, que_write}, 96'd0);
         if (k == rd) begin
            mem_rvalid = 1'b1;
            mem_rdata  = data;
         end
         step();
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
      expPushes++;
      checkOutput("push", {31'd0, que_write, que_wdata}, {31'd0, 1'b1, expAddr, data});
   endtask

   task automatic redirFetch(input int gd, input int rd, input int redirAt,
                             input logic [31:0] target, input logic [31:0] expAddr);
      bit ok;
      waitReq(expAddr, ok);
      if (!ok) return;
      grantAfter(gd, expAddr);
      for (int k = 1; k <= rd; k++) begin
         if (k == redirAt) begin
            redirect    = 1'b1;
            redirect_pc = target;
         end
         if (k == rd) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 | 32'(k);
         end
         step();
         redirect   = 1'b0;
         mem_rvalid = 1'b0;
         if (k == redirAt) begin
            expFlushes++;
            checkOutput("redirFlush", {93'd0, que_flush, que_write, mem_req}, {93'd0, 3'b100});
         end else begin
            checkOutput("redirQuiet", {93'd0, que_flush, que_write, mem_req}, 96'd0);
         end
      end
   endtask

   task automatic redirectInReq(input logic [31:0] target, input bit withGnt,
                                input logic [31:0] expAddr);
      bit ok;
      waitReq(expAddr, ok);
      if (!ok) return;
      redirect    = 1'b1;
      redirect_pc = target;
      mem_gnt     = withGnt;
      step();
      redirect = 1'b0;
      mem_gnt  = 1'b0;
      expFlushes++;
      checkOutput("reqRedirFlush", {94'd0, que_flush, mem_req}, {94'd0, 2'b10});
      if (withGnt) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hBAD0_BAD0;
         step();
         mem_rvalid = 1'b0;
         checkOutput("staleGntDropped", {93'd0, que_write, que_flush, mem_req}, 96'd0);
      end
   endtask

   task automatic holdFull(input int n, input logic [31:0] expAddr);
      que_full = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         checkOutput("fullNoReq", {94'd0, mem_req, que_write}, 96'd0);
      end
      que_full = 1'b0;
      step();
      checkOutput("fullReleaseReq", {63'd0, mem_req, mem_addr}, {63'd0, 1'b1, expAddr});
   endtask

   typedef struct {
      int          gntDly;
      int          rvDly;
      logic [31:0] rdata;
      logic [31:0] expAddr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [31:0] expPc;
      logic [31:0] target;
      logic [31:0] data;
      bit          ok;

      vecs[0] = '{0, 1, 32'hA000_0000, 32'h0000_0100};
      vecs[1] = '{0, 1, 32'hA000_0001, 32'h0000_0104};
      vecs[2] = '{0, 1, 32'hA000_0002, 32'h0000_0108};
      vecs[3] = '{5, 1, 32'hB000_0003, 32'h0000_010C};
      vecs[4] = '{2, 3, 32'hC000_0004, 32'h0000_0110};
      vecs[5] = '{0, 2, 32'hD000_0005, 32'h0000_0114};

      rst = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      que_full = 1'b0;
      repeat (3) step();
      checkOutput("resetState", {27'd0, mem_req, mem_addr, que_write, que_flush, 32'd0},
                  {27'd0, 1'b0, 32'h100, 1'b0, 1'b0, 32'd0});
      checkOutput("resetWdata", 96'(que_wdata), 96'd0);
      rst = 1'b1;

      for (int i = 0; i < 6; i++)
         applyStimulus(vecs[i].gntDly, vecs[i].rvDly, vecs[i].rdata, vecs[i].expAddr);

      holdFull(6, 32'h118);
      applyStimulus(0, 1, 32'h1111_1111, 32'h118);
      redirFetch(0, 3, 1, 32'h2000, 32'h11C);
      applyStimulus(0, 1, 32'h2222_2222, 32'h2000);
      redirFetch(1, 2, 2, 32'h3000, 32'h2004);
      applyStimulus(0, 1, 32'h3333_3333, 32'h3000);
      redirectInReq(32'h4000, 1'b1, 32'h3004);
      applyStimulus(0, 1, 32'h4444_4444, 32'h4000);
      redirectInReq(32'hFFFF_FFFC, 1'b0, 32'h4004);
      applyStimulus(0, 1, 32'h5555_5555, 32'hFFFF_FFFC);
      applyStimulus(0, 1, 32'h6666_6666, 32'h0000_0000);

      waitReq(32'h4, ok);
      if (ok) begin
         mem_gnt = 1'b1;
         step();
         mem_gnt = 1'b0;
         rst = 1'b0;
         #1;
         checkOutput("asyncReset", {27'd0, mem_req, mem_addr, que_write, que_flush, 32'd0},
                     {27'd0, 1'b0, 32'h100, 1'b0, 1'b0, 32'd0});
         checkOutput("asyncResetWdata", 96'(que_wdata), 96'd0);
         step();
         rst = 1'b1;
         mem_rvalid = 1'b1;
         mem_rdata = 32'hBAD1_BAD1;
         step();
         mem_rvalid = 1'b0;
         checkOutput("postResetRvalidIgnored", {63'd0, que_write, mem_addr}, {63'd0, 1'b0, 32'h100});
      end
      applyStimulus(0, 1, 32'h7777_7777, 32'h100);

      // Reference model: fetch pc advances by 4 per delivered word, redirect replaces it.
      expPc = 32'h104;
      for (int n = 0; n < 40; n++) begin
         data = $urandom;
         if ($urandom_range(0, 4) == 0) holdFull($urandom_range(1, 4), expPc);
         if ($urandom_range(0, 3) == 0) begin
            int rd;
            target = $urandom & 32'hFFFF_FFFC;
            rd = $urandom_range(1, 3);
            redirFetch($urandom_range(0, 3), rd, $urandom_range(1, rd), target, expPc);
            expPc = target;
         end else begin
            applyStimulus($urandom_range(0, 3), $urandom_range(1, 3), data, expPc);
            expPc = expPc + 32'd4;
         end
      end

      step();
      step();
      checkOutput("totalPushes", 96'(pushCount), 96'(expPushes));
      checkOutput("totalFlushes", 96'(flushCount), 96'(expFlushes));
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
